// File: rtl/loss_comp_pkg.sv
// loss_comp_pkg: state encoding, timeout default and lane sizing helpers for the gain calibration loop
package loss_comp_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_SETTLE, S_ACCUM, S_DECIDE, S_DONE, S_FAIL
    } state_e;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
    function automatic int lanes_f(input int data_w, input int word_w);
        return data_w / word_w;
    endfunction
    function automatic int log2_f(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction
endpackage

// File: rtl/loss_comp_beat_sum.sv
// loss_comp_beat_sum: registered unsigned sum of all lanes of a beat, valid pipelined alongside
module loss_comp_beat_sum #(
    parameter int DATA_WIDTH = 256,
    parameter int WORD_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int SUM_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [SUM_W-1:0]      sum,
    output logic                  sum_valid
);
    logic [SUM_W-1:0] sum_d, sum_q;
    logic             valid_d, valid_q;
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++)
            sum_d = sum_d + SUM_W'(in_data[i*WORD_WIDTH +: WORD_WIDTH]);
        valid_d = in_valid;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end
    assign sum       = sum_q;
    assign sum_valid = valid_q;
endmodule

// File: rtl/loss_comp_gain_ctrl.sv
// loss_comp_gain_ctrl: MSB-first binary search of compensator gain against a target mean level;
// define LOSS_COMP_TIMEOUT_EN to abort a measurement window that stalls without valid beats.
module loss_comp_gain_ctrl
    import loss_comp_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int WORD_WIDTH    = 16,
    parameter int GAIN_BITS     = 8,
    parameter int ACC_LOG2      = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAIN_DEFAULT  = 1
`ifdef LOSS_COMP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cal_start,
    input  logic [WORD_WIDTH-1:0] target_level,
    input  logic [DATA_WIDTH-1:0] adc_tdata,
    input  logic                  adc_tvalid,
    output logic [WORD_WIDTH-1:0] multiply,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic                  cal_fail,
    output logic                  cal_locked
);
    localparam int LANES      = lanes_f(DATA_WIDTH, WORD_WIDTH);
    localparam int LOG2_LANES = log2_f(LANES);
    localparam int SUM_W      = WORD_WIDTH + LOG2_LANES;
    localparam int ACC_W      = SUM_W + ACC_LOG2;
    localparam int SET_W      = $clog2(SETTLE_CYCLES + 1);
    localparam int IDX_W      = $clog2(GAIN_BITS + 1);
    localparam logic [WORD_WIDTH-1:0] GAIN_RST = WORD_WIDTH'(GAIN_DEFAULT);
`ifdef LOSS_COMP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] stall_q, stall_d;
`endif
    state_e                state_q, state_d;
    logic [GAIN_BITS-1:0]  trial_q, trial_d, trial_new, bit_mask;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] target_q, target_d, locked_q, locked_d, multiply_q, multiply_d, mean;
    logic                  cal_locked_q, cal_locked_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [ACC_LOG2-1:0]   beats_q, beats_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [SUM_W-1:0]      beat_sum;
    logic                  beat_valid;

    loss_comp_beat_sum #(
        .DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH), .LANES(LANES), .SUM_W(SUM_W)
    ) u_sum (
        .clk(clk), .rst_n(rst_n), .in_data(adc_tdata), .in_valid(adc_tvalid),
        .sum(beat_sum), .sum_valid(beat_valid)
    );

    // The top WORD_WIDTH bits of the window total are the mean lane value.
    assign mean      = acc_q[ACC_W-1 -: WORD_WIDTH];
    assign bit_mask  = GAIN_BITS'(1) << idx_q;
    assign trial_new = (mean <= target_q) ? trial_q : (trial_q & ~bit_mask);

    always_comb begin
        state_d      = state_q;
        trial_d      = trial_q;
        idx_d        = idx_q;
        target_d     = target_q;
        locked_d     = locked_q;
        multiply_d   = multiply_q;
        cal_locked_d = cal_locked_q;
        settle_d     = settle_q;
        beats_d      = beats_q;
        acc_d        = acc_q;
`ifdef LOSS_COMP_TIMEOUT_EN
        stall_d      = stall_q;
`endif
        case (state_q)
            S_IDLE: if (cal_start) begin
                state_d      = S_SET;
                target_d     = target_level;
                trial_d      = '0;
                idx_d        = IDX_W'(GAIN_BITS - 1);
                cal_locked_d = 1'b0;
            end
            S_SET: begin
                trial_d    = trial_q | bit_mask;
                multiply_d = WORD_WIDTH'(trial_q | bit_mask);
                settle_d   = '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    acc_d   = '0;
                    beats_d = '0;
`ifdef LOSS_COMP_TIMEOUT_EN
                    stall_d = '0;
`endif
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_valid) begin
                    acc_d   = acc_q + ACC_W'(beat_sum);
                    beats_d = beats_q + ACC_LOG2'(1);
                    state_d = (&beats_q) ? S_DECIDE : S_ACCUM;
                end
`ifdef LOSS_COMP_TIMEOUT_EN
                stall_d = beat_valid ? '0 : stall_q + TO_W'(1);
                if (!beat_valid && stall_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_FAIL;
                    multiply_d = locked_q;
                end
`endif
            end
            S_DECIDE: begin
                trial_d = trial_new;
                if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_SET;
                end else if ((&trial_new) && mean < target_q) begin
                    // Even the largest gain cannot reach target: keep the old lock.
                    state_d    = S_FAIL;
                    multiply_d = locked_q;
                end else begin
                    state_d      = S_DONE;
                    locked_d     = WORD_WIDTH'(trial_new);
                    multiply_d   = WORD_WIDTH'(trial_new);
                    cal_locked_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            trial_q      <= '0;
            idx_q        <= '0;
            target_q     <= '0;
            locked_q     <= GAIN_RST;
            multiply_q   <= GAIN_RST;
            cal_locked_q <= 1'b0;
            settle_q     <= '0;
            beats_q      <= '0;
            acc_q        <= '0;
`ifdef LOSS_COMP_TIMEOUT_EN
            stall_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            trial_q      <= trial_d;
            idx_q        <= idx_d;
            target_q     <= target_d;
            locked_q     <= locked_d;
            multiply_q   <= multiply_d;
            cal_locked_q <= cal_locked_d;
            settle_q     <= settle_d;
            beats_q      <= beats_d;
            acc_q        <= acc_d;
`ifdef LOSS_COMP_TIMEOUT_EN
            stall_q      <= stall_d;
`endif
        end
    end

    assign multiply   = multiply_q;
    assign cal_busy   = state_q inside {S_SET, S_SETTLE, S_ACCUM, S_DECIDE};
    assign cal_done   = state_q == S_DONE;
    assign cal_fail   = state_q == S_FAIL;
    assign cal_locked = cal_locked_q;
endmodule

// File: tb/tb_loss_comp_gain_ctrl.sv
// tb_loss_comp_gain_ctrl: directed calibration scenarios against a 2-cycle compensator model
module tb_loss_comp_gain_ctrl;
    localparam int LANES = 16;
    logic         clk = 1'b0;
    logic         rst_n, cal_start, pre_valid, toggle;
    logic [15:0]  target_level, multiply;
    logic [7:0]   pre_hi;
    logic [255:0] s1, s2;
    logic         s1v, s2v;
    logic         cal_busy, cal_done, cal_fail, cal_locked;
    int           ph = 0;
    int           checks = 0;
    int           errors = 0;
    int           cyc;
    bit           got_done, got_fail, pulse;
    logic [15:0]  max_mul;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ph <= (ph == 2) ? 0 : ph + 1;
        for (int i = 0; i < LANES; i++) s1[i*16 +: 16] <= 16'(pre_hi * multiply);
        s1v <= pre_valid & (!toggle || ph == 0);
        s2  <= s1;
        s2v <= s1v;
    end

    loss_comp_gain_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .target_level(target_level),
        .adc_tdata(s2), .adc_tvalid(s2v), .multiply(multiply),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .cal_locked(cal_locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with cal_start already driven; cycle 1 is the first state after acceptance.
    task automatic run_cal(input int budget, output int n, output bit d, output bit f, output logic [15:0] mx);
        n = 0; d = 0; f = 0; mx = '0;
        while (!d && !f && n < budget) begin
            @(negedge clk);
            cal_start = 1'b0;
            n++;
            if (multiply > mx) mx = multiply;
            d = cal_done;
            f = cal_fail;
        end
    endtask

    task automatic check_idle_status(input string tag, input logic [15:0] mul);
        check({tag, "_mul"}, multiply, mul);
        check({tag, "_busy"}, cal_busy, 0);
        check({tag, "_done"}, cal_done, 0);
        check({tag, "_fail"}, cal_fail, 0);
        check({tag, "_locked"}, cal_locked, 0);
    endtask

    initial begin
        rst_n = 1'b0; cal_start = 1'b0; target_level = '0;
        pre_hi = 8'd4; pre_valid = 1'b1; toggle = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_status("reset", 16'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Lane = 4*gain, target 400 -> largest gain with mean <= 400 is 100
        target_level = 16'd400; cal_start = 1'b1;
        run_cal(3000, cyc, got_done, got_fail, max_mul);
        check("t1_done", got_done, 1);
        check("t1_fail", got_fail, 0);
        check("t1_cycles", cyc, 561);
        check("t1_mul", multiply, 100);
        check("t1_locked", cal_locked, 1);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        check("t1_done_pulse", cal_done, 0);
        check("t1_start_in_done_ignored", cal_busy, 0);
        repeat (5) @(negedge clk);
        check("t1_idle_busy", cal_busy, 0);
        check("t1_hold_mul", multiply, 100);

        // Zero input never reaches target: search saturates at 0xFF and fails
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pre_hi = 8'd0; target_level = 16'd10; cal_start = 1'b1;
        run_cal(3000, cyc, got_done, got_fail, max_mul);
        check("t2_fail", got_fail, 1);
        check("t2_done", got_done, 0);
        check("t2_mul_restored", multiply, 1);
        check("t2_locked", cal_locked, 0);
        check("t2_max_trial", max_mul, 255);
        @(negedge clk);
        check("t2_fail_pulse", cal_fail, 0);

        // Valid on one cycle in three: each window spans 190..192 cycles
        pre_hi = 8'd4; toggle = 1'b1; target_level = 16'd400;
        repeat (4) @(negedge clk);
        cal_start = 1'b1;
        run_cal(3000, cyc, got_done, got_fail, max_mul);
        check("t3_done", got_done, 1);
        check("t3_mul", multiply, 100);
        check("t3_locked", cal_locked, 1);
        check("t3_cycle_window", (cyc >= 1569 && cyc <= 1585), 1);
        toggle = 1'b0;

        // Reset during the bit-5 measurement window aborts silently
        repeat (4) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        pulse = 0;
        repeat (169) begin
            @(negedge clk);
            pulse |= cal_done | cal_fail;
        end
        check("t4_busy_before_reset", cal_busy, 1);
        check("t4_no_pulse", pulse, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_status("t4_reset", 16'd1);
        rst_n = 1'b1;
        @(negedge clk);
        cal_start = 1'b1;
        run_cal(3000, cyc, got_done, got_fail, max_mul);
        check("t4_done", got_done, 1);
        check("t4_mul", multiply, 100);
        check("t4_cycles", cyc, 561);

        // No valid beats in the measurement window
        pre_valid = 1'b0;
        repeat (4) @(negedge clk);
        cal_start = 1'b1;
`ifdef LOSS_COMP_TIMEOUT_EN
        run_cal(3000, cyc, got_done, got_fail, max_mul);
        check("t5_fail", got_fail, 1);
        check("t5_cycles", cyc, 1030);
        check("t5_mul_restored", multiply, 100);
        check("t5_locked", cal_locked, 0);
`else
        run_cal(5000, cyc, got_done, got_fail, max_mul);
        check("t5_no_done", got_done, 0);
        check("t5_no_fail", got_fail, 0);
        check("t5_still_busy", cal_busy, 1);
        check("t5_cycles", cyc, 5000);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
